// File: rtl/pipe_drain_buffer_pkg.sv
// Shared definitions for the pipeline drain buffer: width helpers, defaults and fill modes.
package pipe_drain_buffer_pkg;

    localparam int unsigned DEF_N     = 16;
    localparam int unsigned DEF_M     = 4;
    localparam int unsigned DEF_DEPTH = 8;

    typedef enum logic [1:0] {
        MODE_EMPTY   = 2'd0,
        MODE_PARTIAL = 2'd1,
        MODE_FULL    = 2'd2
    } fill_mode_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Read/write pointer width for a FIFO of the given depth.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return clog2(depth);
    endfunction

    // Occupancy/credit counter width: must hold the value depth itself.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return clog2(depth + 1);
    endfunction

    function automatic fill_mode_e mode_of(input int unsigned count, input int unsigned depth);
        if (count == 0) begin
            return MODE_EMPTY;
        end
        if (count >= depth) begin
            return MODE_FULL;
        end
        return MODE_PARTIAL;
    endfunction

endpackage

// File: rtl/pipe_drain_buffer_fifo_ram.sv
// DEPTH x N register array, one synchronous write port and one asynchronous read port.
module fifo_ram
    import pipe_drain_buffer_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned PTR_W = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [N-1:0]     wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [N-1:0]     rdata
);

    logic [N-1:0] mem_q [DEPTH];

    // Contents are intentionally not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/pipe_drain_buffer.sv
// Receive-side buffer for a fixed-latency pipeline: FIFO plus issue-credit counter.
module pipe_drain_buffer
    import pipe_drain_buffer_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned M     = DEF_M,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                           clk,
    input  logic                           reset_n,
    output logic                           issue_ok,
    input  logic                           issue,
    input  logic                           pipe_valid,
    input  logic [N-1:0]                   pipe_data,
    output logic                           out_valid,
    output logic [N-1:0]                   out_data,
    input  logic                           out_ready,
    output logic [cnt_width(DEPTH)-1:0]    credits,
    output logic                           err
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Credits only guarantee a slot if every in-flight word fits in the FIFO.
    if (DEPTH < M || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pipe_drain_buffer: DEPTH must be a power of two, >= 2 and >= M");
    end

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] credits_q, credits_d;
    logic             err_q, err_d;
    logic             out_valid_q, out_valid_d;
    logic             issue_ok_q, issue_ok_d;

    fill_mode_e mode_c;
    fill_mode_e next_mode_c;
    logic       pop_c;
    logic       push_ok_c;
    logic       push_drop_c;
    logic       credit_err_c;

    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        credits_d    = credits_q;
        credit_err_c = 1'b0;

        mode_c      = mode_of(32'(count_q), DEPTH);
        pop_c       = out_valid_q & out_ready;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push_ok_c   = pipe_valid & ((mode_c != MODE_FULL) | pop_c);
        push_drop_c = pipe_valid & ~push_ok_c;

        if (push_ok_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push_ok_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Credits saturate at both ends; hitting either limit is a producer/consumer bug.
        if (issue && !pop_c) begin
            if (credits_q == '0) begin
                credit_err_c = 1'b1;
            end else begin
                credits_d = credits_q - CNT_W'(1);
            end
        end else if (pop_c && !issue) begin
            if (credits_q == DEPTH_C) begin
                credit_err_c = 1'b1;
            end else begin
                credits_d = credits_q + CNT_W'(1);
            end
        end

        next_mode_c = mode_of(32'(count_d), DEPTH);
        err_d       = err_q | push_drop_c | credit_err_c;
        out_valid_d = (next_mode_c != MODE_EMPTY);
        issue_ok_d  = (credits_d != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            credits_q   <= DEPTH_C;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            issue_ok_q  <= 1'b1;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            credits_q   <= credits_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            issue_ok_q  <= issue_ok_d;
        end
    end

    fifo_ram #(
        .N     (N),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo_ram (
        .clk   (clk),
        .we    (push_ok_c),
        .waddr (wr_ptr_q),
        .wdata (pipe_data),
        .raddr (rd_ptr_q),
        .rdata (out_data)
    );

    assign issue_ok  = issue_ok_q;
    assign out_valid = out_valid_q;
    assign credits   = credits_q;
    assign err       = err_q;

endmodule

// File: tb/tb_pipe_drain_buffer.sv
// Scoreboard bench for pipe_drain_buffer with a 4-stage upstream pipeline model.
module tb_pipe_drain_buffer;

    localparam int unsigned N     = 16;
    localparam int unsigned M     = 4;
    localparam int unsigned DEPTH = 8;

    logic          clk;
    logic          reset_n;
    logic          issue_ok;
    logic          issue;
    logic          pipe_valid;
    logic [N-1:0]  pipe_data;
    logic          out_valid;
    logic [N-1:0]  out_data;
    logic          out_ready;
    logic [3:0]    credits;
    logic          err;

    int total;
    int bad;
    int rx_count;

    logic [N-1:0] exp_q [$];

    logic          tb_pipe_en;
    logic [N-1:0]  iss_data;
    logic          inj_v;
    logic [N-1:0]  inj_d;
    logic          sv [M];
    logic [N-1:0]  sd [M];

    pipe_drain_buffer #(.N(N), .M(M), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .issue_ok   (issue_ok),
        .issue      (issue),
        .pipe_valid (pipe_valid),
        .pipe_data  (pipe_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .credits    (credits),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream pipeline: word issued in cycle c appears on pipe_valid in cycle c+M.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(M); i++) begin
                sv[i] <= 1'b0;
                sd[i] <= '0;
            end
        end else begin
            sv[0] <= issue & tb_pipe_en;
            sd[0] <= iss_data;
            for (int i = 1; i < int'(M); i++) begin
                sv[i] <= sv[i-1];
                sd[i] <= sd[i-1];
            end
        end
    end

    assign pipe_valid = inj_v | sv[M-1];
    assign pipe_data  = inj_v ? inj_d : sd[M-1];

    // Monitor: every accepted output word must match the scoreboard head.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            total++;
            rx_count++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got %04h want <none>", out_data);
            end else begin
                logic [N-1:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    bad++;
                    $display("FAIL pop_data: got %04h want %04h", out_data, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_word(input logic [N-1:0] d);
        issue    = 1'b1;
        iss_data = d;
        exp_q.push_back(d);
        step();
        issue = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(n < budget), 32'd1);
    endtask

    task automatic fill_with(input logic [N-1:0] base, output int issued);
        issued = 0;
        for (int c = 0; c < 20; c++) begin
            if (issue_ok) begin
                issue_word(base + N'(issued));
                issued++;
            end else begin
                step();
            end
        end
    endtask

    initial begin
        int nissued;
        int rx_start;

        total      = 0;
        bad        = 0;
        rx_count   = 0;
        reset_n    = 1'b0;
        issue      = 1'b0;
        iss_data   = '0;
        out_ready  = 1'b0;
        tb_pipe_en = 1'b1;
        inj_v      = 1'b0;
        inj_d      = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        check("rst_credits", 32'(credits), 32'd8);
        check("rst_issue_ok", 32'(issue_ok), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // Single word round trip
        out_ready = 1'b1;
        issue_word(16'hA5A5);
        check("single_credits_after_issue", 32'(credits), 32'd7);
        repeat (3) step();
        check("single_pipe_valid_c4", 32'(pipe_valid), 32'd1);
        check("single_out_valid_c4", 32'(out_valid), 32'd0);
        step();
        check("single_out_valid_c5", 32'(out_valid), 32'd1);
        check("single_out_data_c5", 32'(out_data), 32'h0000A5A5);
        check("single_credits_c5", 32'(credits), 32'd7);
        step();
        check("single_credits_c6", 32'(credits), 32'd8);
        check("single_out_valid_c6", 32'(out_valid), 32'd0);

        // Back-pressure to full, then drain in order
        out_ready = 1'b0;
        fill_with(16'd1, nissued);
        check("bp_issues", 32'(nissued), 32'd8);
        check("bp_issue_ok", 32'(issue_ok), 32'd0);
        check("bp_credits", 32'(credits), 32'd0);
        check("bp_count", 32'(dut.count_q), 32'd8);
        check("bp_err", 32'(err), 32'd0);
        out_ready = 1'b1;
        wait_drain("bp_drain_timeout", 40);
        check("bp_credits_after", 32'(credits), 32'd8);

        // Wrap-around stream with toggling ready
        rx_start = rx_count;
        nissued  = 0;
        for (int c = 0; c < 300 && (nissued < 20 || exp_q.size() != 0); c++) begin
            out_ready = (c % 2 == 0);
            if (issue_ok && nissued < 20) begin
                issue_word(N'(nissued));
                nissued++;
            end else begin
                step();
            end
        end
        out_ready = 1'b1;
        wait_drain("wrap_drain_timeout", 40);
        check("wrap_rx_words", 32'(rx_count - rx_start), 32'd20);
        check("wrap_credits", 32'(credits), 32'd8);
        check("wrap_err", 32'(err), 32'd0);

        // Simultaneous push and pop at FULL
        out_ready = 1'b0;
        fill_with(16'h0100, nissued);
        check("full_count", 32'(dut.count_q), 32'd8);
        inj_v     = 1'b1;
        inj_d     = 16'h0BEE;
        out_ready = 1'b1;
        exp_q.push_back(16'h0BEE);
        step();
        inj_v     = 1'b0;
        out_ready = 1'b0;
        check("full_both_count", 32'(dut.count_q), 32'd8);
        check("full_both_err", 32'(err), 32'd0);
        check("full_both_credits", 32'(credits), 32'd1);
        check("full_both_new_head", 32'(out_data), 32'h00000101);

        // Issue past zero credits: sticky error
        tb_pipe_en = 1'b0;
        issue      = 1'b1;
        step();
        check("err_credits_zero", 32'(credits), 32'd0);
        check("err_not_yet", 32'(err), 32'd0);
        step();
        issue = 1'b0;
        check("err_set", 32'(err), 32'd1);
        check("err_credits_hold", 32'(credits), 32'd0);
        repeat (3) step();
        check("err_sticky", 32'(err), 32'd1);

        // Drain five, leaving three buffered, then asynchronous reset
        out_ready = 1'b1;
        repeat (5) step();
        out_ready = 1'b0;
        check("mid_count", 32'(dut.count_q), 32'd3);
        check("mid_credits", 32'(credits), 32'd5);
        check("mid_err", 32'(err), 32'd1);
        exp_q.delete();
        #2 reset_n = 1'b0;
        #1;
        check("arst_count", 32'(dut.count_q), 32'd0);
        check("arst_credits", 32'(credits), 32'd8);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_issue_ok", 32'(issue_ok), 32'd1);
        check("arst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        tb_pipe_en = 1'b1;
        repeat (2) step();
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_err", 32'(err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
